// File: rtl/chimera_pad_cfg_apb.sv
// APB completer for the chip pad-configuration registers: per-pad mux select, pulls and drive
// strength, with programmable wait states and a sticky write-protect lock.
module chimera_pad_cfg_apb #(
    parameter int unsigned NumPads    = 32,
    parameter int unsigned WaitCycles = 1,
    parameter type         apb_req_t  = logic [73:0],
    parameter type         apb_resp_t = logic [33:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  apb_req_t                 apb_req_i,
    output apb_resp_t                apb_rsp_o,
    output logic [NumPads-1:0][1:0]  pad_mux_sel_o,
    output logic [NumPads-1:0]       pad_pu_o,
    output logic [NumPads-1:0]       pad_pd_o,
    output logic [NumPads-1:0][1:0]  pad_drv_o,
    output logic                     cfg_locked_o
);

    typedef struct packed {
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic        pwrite;
        logic        psel;
        logic        penable;
        logic [2:0]  pprot;
    } req_t;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
    } rsp_t;

    localparam int unsigned   CntW     = (WaitCycles > 0) ? $clog2(WaitCycles + 1) : 1;
    localparam int unsigned   IdxW     = (NumPads > 1) ? $clog2(NumPads) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WaitCycles);
    localparam logic [9:0]    NumPadsW = 10'(NumPads);
    localparam logic [11:0]   LockOff  = 12'hFFC;

    req_t req;
    rsp_t rsp;

    assign req       = apb_req_i;
    assign apb_rsp_o = rsp;

    logic [NumPads-1:0][1:0] mux_q;
    logic [NumPads-1:0]      pu_q;
    logic [NumPads-1:0]      pd_q;
    logic [NumPads-1:0][1:0] drv_q;
    logic                    locked_q;
    logic [CntW-1:0]         cnt_q, cnt_d;

    logic [11:0]     offset;
    logic [9:0]      word;
    logic [IdxW-1:0] pad_idx;
    logic            is_pad, is_lock, access, pready, slv_err, wr_en;
    logic [31:0]     pad_rdata;

    assign offset  = req.paddr[11:0];
    assign word    = offset[11:2];
    assign pad_idx = word[IdxW-1:0];
    assign is_pad  = (offset[1:0] == 2'b00) && (word < NumPadsW);
    assign is_lock = (offset == LockOff);

    assign access  = req.psel & req.penable;
    // Gated by reset so a zero-wait build cannot complete while reset is held.
    assign pready  = rst_ni & access & (cnt_q == CntMax);
    assign slv_err = ~(is_pad | is_lock) | (req.pwrite & is_pad & locked_q);
    assign wr_en   = pready & req.pwrite & ~slv_err & req.pstrb[0];
    assign cnt_d   = (access && !pready) ? cnt_q + CntW'(1) : '0;

    assign pad_rdata = {26'b0, drv_q[pad_idx], pd_q[pad_idx], pu_q[pad_idx], mux_q[pad_idx]};

    always_comb begin
        rsp = '0;
        if (pready) begin
            rsp.pready  = 1'b1;
            rsp.pslverr = slv_err;
            if (!req.pwrite && !slv_err) begin
                rsp.prdata = is_lock ? {31'b0, locked_q} : pad_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mux_q    <= '0;
            pu_q     <= '0;
            pd_q     <= '0;
            drv_q    <= {NumPads{2'b01}};
            locked_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (wr_en && is_pad) begin
                mux_q[pad_idx] <= req.pwdata[1:0];
                pu_q[pad_idx]  <= req.pwdata[2];
                // Both pulls requested: pull-up wins.
                pd_q[pad_idx]  <= req.pwdata[3] & ~req.pwdata[2];
                drv_q[pad_idx] <= req.pwdata[5:4];
            end
            if (wr_en && is_lock && req.pwdata[0]) begin
                locked_q <= 1'b1;
            end
        end
    end

    assign pad_mux_sel_o = mux_q;
    assign pad_pu_o      = pu_q;
    assign pad_pd_o      = pd_q;
    assign pad_drv_o     = drv_q;
    assign cfg_locked_o  = locked_q;

    logic unused;
    assign unused = ^{req.paddr[31:12], req.pwdata[31:6], req.pstrb[3:1], req.pprot};

endmodule

// File: tb/tb_chimera_pad_cfg_apb.sv
// Bench for chimera_pad_cfg_apb: three builds (WaitCycles 1, 3, 0) driven by directed scenarios
// plus a randomized run against a register-level model.
module tb_chimera_pad_cfg_apb;

    localparam int NPA = 32;
    localparam int NPC = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n;
    logic [73:0] req [3];
    logic [33:0] rsp [3];
    int          wc [3] = '{1, 3, 0};

    logic [NPA-1:0][1:0] mux_a, drv_a, mux_b, drv_b;
    logic [NPA-1:0]      pu_a, pd_a, pu_b, pd_b;
    logic [NPC-1:0][1:0] mux_c, drv_c;
    logic [NPC-1:0]      pu_c, pd_c;
    logic [2:0]          lck;

    int n_pass = 0;
    int n_total = 0;

    chimera_pad_cfg_apb #(.NumPads(NPA), .WaitCycles(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n[0]), .apb_req_i(req[0]), .apb_rsp_o(rsp[0]),
        .pad_mux_sel_o(mux_a), .pad_pu_o(pu_a), .pad_pd_o(pd_a), .pad_drv_o(drv_a),
        .cfg_locked_o(lck[0])
    );
    chimera_pad_cfg_apb #(.NumPads(NPA), .WaitCycles(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n[1]), .apb_req_i(req[1]), .apb_rsp_o(rsp[1]),
        .pad_mux_sel_o(mux_b), .pad_pu_o(pu_b), .pad_pd_o(pd_b), .pad_drv_o(drv_b),
        .cfg_locked_o(lck[1])
    );
    chimera_pad_cfg_apb #(.NumPads(NPC), .WaitCycles(0)) dut_c (
        .clk_i(clk), .rst_ni(rst_n[2]), .apb_req_i(req[2]), .apb_rsp_o(rsp[2]),
        .pad_mux_sel_o(mux_c), .pad_pu_o(pu_c), .pad_pd_o(pd_c), .pad_drv_o(drv_c),
        .cfg_locked_o(lck[2])
    );

    // Register-level model of dut_b.
    logic [5:0] m_pad [NPA];
    logic       m_lock;

    task automatic model_reset();
        for (int i = 0; i < NPA; i++) m_pad[i] = 6'h10;
        m_lock = 1'b0;
    endtask

    task automatic model_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, output logic exp_err,
                              output logic [31:0] exp_rd);
        int off;
        logic [5:0] v;
        off = int'(addr & 32'hFFF);
        exp_err = 1'b0;
        exp_rd = '0;
        if (off % 4 != 0) begin
            exp_err = 1'b1;
        end else if (off == 4092) begin
            if (wr) begin
                if (strb[0] && wdata[0]) m_lock = 1'b1;
            end else begin
                exp_rd = {31'b0, m_lock};
            end
        end else if (off / 4 < NPA) begin
            if (wr) begin
                if (m_lock) exp_err = 1'b1;
                else if (strb[0]) begin
                    v = wdata[5:0];
                    if (v[2]) v[3] = 1'b0;
                    m_pad[off / 4] = v;
                end
            end else begin
                exp_rd = 32'(m_pad[off / 4]);
            end
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // Full transfer: SETUP, then ACCESS until pready (bounded). cycles = -1 on timeout.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err, output int cycles,
                            output logic bad_idle);
        @(negedge clk);
        req[d] = {addr, wdata, strb, wr, 1'b1, 1'b0, 3'($urandom)};
        @(negedge clk);
        req[d][3] = 1'b1;
        cycles = 0;
        bad_idle = 1'b0;
        #1;
        while (rsp[d][1] !== 1'b1 && cycles < 20) begin
            if (rsp[d][33:2] !== 32'h0 || rsp[d][0] !== 1'b0) bad_idle = 1'b1;
            @(negedge clk);
            #1;
            cycles++;
        end
        rdata = rsp[d][33:2];
        err = rsp[d][0];
        if (rsp[d][1] !== 1'b1) cycles = -1;
    endtask

    task automatic apb_idle(input int d);
        @(negedge clk);
        req[d] = '0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic err, bad;
        int cyc;
        n_total++;
        if ({rsp[0], rsp[1], rsp[2]} !== '0) $display("FAIL reset_rsp got %h want 0", {rsp[0], rsp[1], rsp[2]});
        else n_pass++;
        n_total++;
        if (lck !== 3'b000) $display("FAIL reset_lock got %b want 000", lck);
        else n_pass++;
        n_total++;
        if ({mux_a, pu_a, pd_a} !== '0 || drv_a !== {NPA{2'b01}})
            $display("FAIL reset_pads got mux=%h pu=%h pd=%h drv=%h want 0/0/0/5555..", mux_a, pu_a, pd_a, drv_a);
        else n_pass++;
        apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, err, cyc, bad);
        apb_idle(0);
        n_total++;
        if (cyc !== 1) $display("FAIL reset_read_latency got %0d want 1", cyc);
        else n_pass++;
        n_total++;
        if (rd !== 32'h10 || err !== 1'b0) $display("FAIL reset_read got %h/%b want 10/0", rd, err);
        else n_pass++;
        n_total++;
        if (bad !== 1'b0) $display("FAIL reset_read_idle_rsp got nonzero want 0");
        else n_pass++;
    endtask

    task automatic test_pull_conflict();
        logic [31:0] rd;
        logic err, bad;
        int cyc;
        apb_xfer(0, 1'b1, 32'h14, 32'h3F, 4'hF, rd, err, cyc, bad);
        apb_idle(0);
        n_total++;
        if (err !== 1'b0 || cyc !== 1) $display("FAIL pull_write got err=%b cyc=%0d want 0/1", err, cyc);
        else n_pass++;
        n_total++;
        if ({pu_a[5], pd_a[5], drv_a[5], mux_a[5]} !== 6'b10_11_11)
            $display("FAIL pull_pads got pu=%b pd=%b drv=%0d mux=%0d want 1/0/3/3", pu_a[5], pd_a[5], drv_a[5], mux_a[5]);
        else n_pass++;
        apb_xfer(0, 1'b0, 32'h14, 32'h0, 4'hF, rd, err, cyc, bad);
        apb_idle(0);
        n_total++;
        if (rd !== 32'h37 || err !== 1'b0) $display("FAIL pull_readback got %h/%b want 37/0", rd, err);
        else n_pass++;
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        logic err, bad;
        int cyc;
        logic [31:0] addrs [4];
        addrs = '{32'h002, 32'h080, 32'hFF8, 32'h5A5A_5003};
        for (int i = 0; i < 4; i++) begin
            apb_xfer(0, 1'b0, addrs[i], 32'h0, 4'hF, rd, err, cyc, bad);
            apb_idle(0);
            n_total++;
            if (rd !== 32'h0 || err !== 1'b1) $display("FAIL unmapped_read %h got %h/%b want 0/1", addrs[i], rd, err);
            else n_pass++;
        end
        apb_xfer(0, 1'b1, 32'h080, 32'h3F, 4'hF, rd, err, cyc, bad);
        apb_idle(0);
        n_total++;
        if (err !== 1'b1) $display("FAIL unmapped_write got err=%b want 1", err);
        else n_pass++;
        apb_xfer(0, 1'b1, 32'h016, 32'h01, 4'hF, rd, err, cyc, bad);
        apb_idle(0);
        n_total++;
        if (err !== 1'b1 || {drv_a[5], pd_a[5], pu_a[5], mux_a[5]} !== 6'h37)
            $display("FAIL misaligned_write got err=%b pad5=%h want 1/37", err, {drv_a[5], pd_a[5], pu_a[5], mux_a[5]});
        else n_pass++;
        apb_xfer(0, 1'b0, 32'hABCD_E014, 32'h0, 4'hF, rd, err, cyc, bad);
        apb_idle(0);
        n_total++;
        if (rd !== 32'h37 || err !== 1'b0) $display("FAIL upper_addr_ignored got %h/%b want 37/0", rd, err);
        else n_pass++;
    endtask

    task automatic test_lock();
        logic [31:0] rd;
        logic err, bad;
        int cyc;
        apb_xfer(0, 1'b1, 32'hFFC, 32'h1, 4'h1, rd, err, cyc, bad);
        apb_idle(0);
        n_total++;
        if (err !== 1'b0 || lck[0] !== 1'b1) $display("FAIL lock_set got err=%b locked=%b want 0/1", err, lck[0]);
        else n_pass++;
        apb_xfer(0, 1'b1, 32'h0C, 32'h2, 4'hF, rd, err, cyc, bad);
        apb_idle(0);
        n_total++;
        if (err !== 1'b1 || mux_a[3] !== 2'd0) $display("FAIL locked_write got err=%b mux3=%0d want 1/0", err, mux_a[3]);
        else n_pass++;
        apb_xfer(0, 1'b0, 32'h0C, 32'h0, 4'hF, rd, err, cyc, bad);
        apb_idle(0);
        n_total++;
        if (rd !== 32'h10 || err !== 1'b0) $display("FAIL locked_read got %h/%b want 10/0", rd, err);
        else n_pass++;
        apb_xfer(0, 1'b1, 32'hFFC, 32'h0, 4'hF, rd, err, cyc, bad);
        apb_idle(0);
        n_total++;
        if (err !== 1'b0 || lck[0] !== 1'b1) $display("FAIL lock_clear_attempt got err=%b locked=%b want 0/1", err, lck[0]);
        else n_pass++;
        apb_xfer(0, 1'b0, 32'hFFC, 32'h0, 4'hF, rd, err, cyc, bad);
        apb_idle(0);
        n_total++;
        if (rd !== 32'h1 || err !== 1'b0) $display("FAIL lock_read got %h/%b want 1/0", rd, err);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic err, bad, exp_err, seen;
        logic [31:0] exp_rd;
        int cyc;
        @(negedge clk);
        req[1] = {32'h04, 32'h2A, 4'hF, 1'b1, 1'b1, 1'b0, 3'b000};
        @(negedge clk);
        req[1][3] = 1'b1;
        #1;
        seen = rsp[1][1];
        @(negedge clk);
        req[1] = '0;
        repeat (4) begin
            @(negedge clk);
            seen |= rsp[1][1];
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL abort_pready got 1 want 0");
        else n_pass++;
        apb_xfer(1, 1'b0, 32'h04, 32'h0, 4'hF, rd, err, cyc, bad);
        apb_idle(1);
        n_total++;
        if (rd !== 32'h10 || cyc !== 3) $display("FAIL abort_no_write got %h cyc=%0d want 10/3", rd, cyc);
        else n_pass++;
        apb_xfer(1, 1'b1, 32'h04, 32'h2A, 4'hF, rd, err, cyc, bad);
        apb_idle(1);
        model_xfer(1'b1, 32'h04, 32'h2A, 4'hF, exp_err, exp_rd);
        n_total++;
        if (cyc !== 3 || err !== 1'b0 || bad !== 1'b0)
            $display("FAIL full_write_w3 got cyc=%0d err=%b idle_bad=%b want 3/0/0", cyc, err, bad);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wdata, exp_rd;
        logic err, bad, exp_err, wr;
        logic [3:0] strb;
        int cyc, kind, idx;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            idx = int'($urandom_range(0, NPA - 1));
            wr = 1'($urandom);
            wdata = $urandom;
            strb = 4'($urandom);
            addr = {$urandom} & 32'hFFFF_F000;
            if (kind <= 5) addr |= 32'(idx * 4);
            else if (kind == 6) begin
                addr |= 32'hFFC;
                if ($urandom_range(0, 15) != 0) wdata[0] = 1'b0;
            end else if (kind == 7) addr |= 32'(idx * 4 + int'($urandom_range(1, 3)));
            else if (kind == 8) addr |= 32'(4 * int'($urandom_range(NPA, 1022)));
            else addr |= 32'($urandom_range(0, 4095));
            model_xfer(wr, addr, wdata, strb, exp_err, exp_rd);
            apb_xfer(1, wr, addr, wdata, strb, rd, err, cyc, bad);
            apb_idle(1);
            n_total++;
            if (err !== exp_err || cyc !== 3)
                $display("FAIL rand_resp a=%h w=%b got err=%b cyc=%0d want %b/3", addr, wr, err, cyc, exp_err);
            else n_pass++;
            if (!wr) begin
                n_total++;
                if (rd !== exp_rd) $display("FAIL rand_rdata a=%h got %h want %h", addr, rd, exp_rd);
                else n_pass++;
            end
            n_total++;
            if ({drv_b[idx], pd_b[idx], pu_b[idx], mux_b[idx]} !== m_pad[idx] || lck[1] !== m_lock)
                $display("FAIL rand_pads pad=%0d got %h lock=%b want %h lock=%b", idx,
                         {drv_b[idx], pd_b[idx], pu_b[idx], mux_b[idx]}, lck[1], m_pad[idx], m_lock);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic err, bad;
        int cyc;
        apb_xfer(2, 1'b1, 32'h18, 32'h25, 4'hF, rd, err, cyc, bad);
        n_total++;
        if (cyc !== 0 || err !== 1'b0) $display("FAIL b2b_write got cyc=%0d err=%b want 0/0", cyc, err);
        else n_pass++;
        apb_xfer(2, 1'b0, 32'h18, 32'h0, 4'hF, rd, err, cyc, bad);
        n_total++;
        if (cyc !== 0 || rd !== 32'h25 || err !== 1'b0)
            $display("FAIL b2b_read got cyc=%0d rd=%h err=%b want 0/25/0", cyc, rd, err);
        else n_pass++;
        apb_xfer(2, 1'b1, 32'h18, 32'h03, 4'b1110, rd, err, cyc, bad);
        apb_xfer(2, 1'b0, 32'h18, 32'h0, 4'hF, rd, err, cyc, bad);
        n_total++;
        if (rd !== 32'h25 || err !== 1'b0) $display("FAIL strobe_gated got %h/%b want 25/0", rd, err);
        else n_pass++;
        apb_xfer(2, 1'b0, 32'h1C, 32'h0, 4'hF, rd, err, cyc, bad);
        n_total++;
        if (rd !== 32'h0 || err !== 1'b1) $display("FAIL past_last_pad got %h/%b want 0/1", rd, err);
        else n_pass++;
        apb_xfer(2, 1'b1, 32'hFFC, 32'h1, 4'b1110, rd, err, cyc, bad);
        apb_idle(2);
        n_total++;
        if (err !== 1'b0 || lck[2] !== 1'b0) $display("FAIL lock_strobe_gated got err=%b lock=%b want 0/0", err, lck[2]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic err, bad;
        int cyc;
        apb_xfer(2, 1'b1, 32'hFFC, 32'h1, 4'hF, rd, err, cyc, bad);
        @(negedge clk);
        req[2] = {32'h18, 32'h01, 4'hF, 1'b1, 1'b1, 1'b0, 3'b000};
        @(negedge clk);
        req[2][3] = 1'b1;
        #1;
        n_total++;
        if (rsp[2][1] !== 1'b1 || lck[2] !== 1'b1) $display("FAIL mid_pre got pready=%b lock=%b want 1/1", rsp[2][1], lck[2]);
        else n_pass++;
        rst_n[2] = 1'b0;
        #1;
        n_total++;
        if (rsp[2] !== 34'h0 || lck[2] !== 1'b0) $display("FAIL mid_rst_rsp got %h lock=%b want 0/0", rsp[2], lck[2]);
        else n_pass++;
        n_total++;
        if ({mux_c, pu_c, pd_c} !== '0 || drv_c !== {NPC{2'b01}})
            $display("FAIL mid_rst_pads got mux=%h pu=%h pd=%h drv=%h", mux_c, pu_c, pd_c, drv_c);
        else n_pass++;
        @(negedge clk);
        req[2] = '0;
        @(negedge clk);
        rst_n[2] = 1'b1;
        apb_xfer(2, 1'b0, 32'h18, 32'h0, 4'hF, rd, err, cyc, bad);
        apb_idle(2);
        n_total++;
        if (rd !== 32'h10 || err !== 1'b0) $display("FAIL mid_rst_lost_write got %h/%b want 10/0", rd, err);
        else n_pass++;
    endtask

    initial begin
        rst_n = 3'b000;
        for (int i = 0; i < 3; i++) req[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 3'b111;
        #1;
        test_reset();
        test_pull_conflict();
        test_unmapped();
        test_lock();
        test_abort();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
